// File: rtl/dpll_control.sv
// dpll_control: central sequencer of the DPLL solver.
// It runs BCP, drains the imply stack and makes decisions from the decider
// memory. Every assignment is recorded on the trace stack. On a conflict it
// backtracks chronologically and flips the newest decision. The result is
// reported as sticky sat/unsat flags.
//
// Strobe semantics: every strobe (pop_*, push_*, write_vs, read_*) is a
// single-cycle combinational decode of the current state and inputs. A strobe
// that is high during a cycle takes effect at the next rising clock edge.
// Stacks are show-ahead: the top entry is valid whenever the stack is not
// empty. Memory/table reads return data one cycle after their read strobe.
module dpll_control #(
   parameter int VAR_BITS    = 8,
   parameter int CLAUSE_BITS = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   bcp_busy,
   input  logic                   conflict,
   output logic [CLAUSE_BITS-1:0] bcp_clause_idx,
   output logic                   reset_bcp,
   input  logic                   empty_imply,
   input  logic [VAR_BITS-1:0]    var_out_imply,
   input  logic                   val_out_imply,
   input  logic                   type_out_imply,
   output logic                   pop_imply,
   input  logic                   empty_trace,
   input  logic [VAR_BITS-1:0]    var_out_trace,
   input  logic                   val_out_trace,
   input  logic                   type_out_trace,
   output logic                   pop_trace,
   output logic                   push_trace,
   output logic [VAR_BITS-1:0]    var_in_trace,
   output logic                   val_in_trace,
   output logic                   type_in_trace,
   output logic                   write_vs,
   output logic [VAR_BITS-1:0]    var_in_vs,
   output logic                   val_in_vs,
   output logic                   unassign_in_vs,
   input  logic [CLAUSE_BITS-1:0] start_clause,
   input  logic [CLAUSE_BITS-1:0] end_clause,
   output logic                   read_var_start_end,
   output logic [VAR_BITS-1:0]    var_in_vse,
   input  logic [VAR_BITS-1:0]    var_idx_d,
   input  logic                   val_d,
   output logic                   read_d,
   output logic [VAR_BITS-1:0]    dec_idx_d_in,
   input  logic [VAR_BITS-1:0]    dec_idx_ds_out,
   input  logic                   empty_ds,
   output logic                   push_ds,
   output logic                   pop_ds,
   output logic [VAR_BITS-1:0]    dec_idx_ds_in,
   output logic                   sat,
   output logic                   unsat,
   output logic [3:0]             state_out
);

   localparam logic [3:0] S_BCP_WAIT      = 4'd0;
   localparam logic [3:0] S_IMPLY         = 4'd1;
   localparam logic [3:0] S_DECIDE        = 4'd2;
   localparam logic [3:0] S_DECIDE_ASSIGN = 4'd3;
   localparam logic [3:0] S_BACKTRACK     = 4'd4;
   localparam logic [3:0] S_FLIP          = 4'd5;
   localparam logic [3:0] S_VSE_READ      = 4'd6;
   localparam logic [3:0] S_BCP_LAUNCH    = 4'd7;
   localparam logic [3:0] S_SAT           = 4'd8;
   localparam logic [3:0] S_UNSAT         = 4'd9;

   logic [3:0]             state_q, state_d;
   logic [VAR_BITS-1:0]    dec_ptr_q, dec_ptr_d;
   logic [VAR_BITS-1:0]    cur_var_q, cur_var_d;
   logic                   cur_val_q, cur_val_d;
   logic [CLAUSE_BITS-1:0] clause_idx_q, clause_idx_d;

   // Solving starts on reset release. The end of a variable's clause range is
   // tracked by the BCP core itself, and the imply entry type is implied
   // (always forced), so these inputs are intentionally not consumed here.
   logic unused_inputs;
   assign unused_inputs = ^{start, end_clause, type_out_imply};

   // State and datapath registers; reset parks the sequencer in BCP_WAIT
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_BCP_WAIT;
         dec_ptr_q    <= VAR_BITS'(1);
         cur_var_q    <= '0;
         cur_val_q    <= 1'b0;
         clause_idx_q <= '0;
      end else begin
         state_q      <= state_d;
         dec_ptr_q    <= dec_ptr_d;
         cur_var_q    <= cur_var_d;
         cur_val_q    <= cur_val_d;
         clause_idx_q <= clause_idx_d;
      end
   end

   // Next-state logic and strobe decode
   always_comb begin
      state_d            = state_q;
      dec_ptr_d          = dec_ptr_q;
      cur_var_d          = cur_var_q;
      cur_val_d          = cur_val_q;
      clause_idx_d       = clause_idx_q;
      pop_imply          = 1'b0;
      pop_trace          = 1'b0;
      push_trace         = 1'b0;
      var_in_trace       = '0;
      val_in_trace       = 1'b0;
      type_in_trace      = 1'b0;
      write_vs           = 1'b0;
      var_in_vs          = '0;
      val_in_vs          = 1'b0;
      unassign_in_vs     = 1'b0;
      read_var_start_end = 1'b0;
      var_in_vse         = cur_var_q;
      read_d             = 1'b0;
      push_ds            = 1'b0;
      pop_ds             = 1'b0;
      dec_idx_ds_in      = dec_ptr_q;

      case (state_q)
         S_BCP_WAIT: begin
            // conflict is only meaningful once the BCP core has gone idle
            if (!bcp_busy) begin
               state_d = conflict ? S_BACKTRACK : S_IMPLY;
            end
         end

         S_IMPLY: begin
            if (empty_imply) begin
               state_d = S_DECIDE;
            end else begin
               pop_imply     = 1'b1;
               write_vs      = 1'b1;
               var_in_vs     = var_out_imply;
               val_in_vs     = val_out_imply;
               push_trace    = 1'b1;
               var_in_trace  = var_out_imply;
               val_in_trace  = val_out_imply;
               type_in_trace = 1'b1;
               cur_var_d     = var_out_imply;
               cur_val_d     = val_out_imply;
               state_d       = S_VSE_READ;
            end
         end

         S_DECIDE: begin
            read_d  = 1'b1;
            state_d = S_DECIDE_ASSIGN;
         end

         S_DECIDE_ASSIGN: begin
            // index 0 terminates the decider list: everything is assigned
            if (var_idx_d == '0) begin
               state_d = S_SAT;
            end else begin
               write_vs      = 1'b1;
               var_in_vs     = var_idx_d;
               val_in_vs     = val_d;
               push_trace    = 1'b1;
               var_in_trace  = var_idx_d;
               val_in_trace  = val_d;
               type_in_trace = 1'b0;
               push_ds       = 1'b1;
               dec_ptr_d     = dec_ptr_q + VAR_BITS'(1);
               cur_var_d     = var_idx_d;
               cur_val_d     = val_d;
               state_d       = S_VSE_READ;
            end
         end

         S_BACKTRACK: begin
            if (empty_trace) begin
               state_d = S_UNSAT;
            end else begin
               pop_trace = 1'b1;
               if (type_out_trace) begin
                  // forced entry: undo it and keep unwinding
                  write_vs       = 1'b1;
                  var_in_vs      = var_out_trace;
                  unassign_in_vs = 1'b1;
               end else begin
                  // newest decision reached: remember it for the flip
                  cur_var_d = var_out_trace;
                  cur_val_d = val_out_trace;
                  state_d   = S_FLIP;
               end
            end
         end

         S_FLIP: begin
            // the flipped value is forced, so it is never flipped again
            write_vs      = 1'b1;
            var_in_vs     = cur_var_q;
            val_in_vs     = !cur_val_q;
            push_trace    = 1'b1;
            var_in_trace  = cur_var_q;
            val_in_trace  = !cur_val_q;
            type_in_trace = 1'b1;
            if (!empty_ds) begin
               pop_ds    = 1'b1;
               dec_ptr_d = dec_idx_ds_out + VAR_BITS'(1);
            end
            state_d = S_VSE_READ;
         end

         S_VSE_READ: begin
            read_var_start_end = 1'b1;
            state_d            = S_BCP_LAUNCH;
         end

         S_BCP_LAUNCH: begin
            clause_idx_d = start_clause;
            state_d      = S_BCP_WAIT;
         end

         S_SAT:   state_d = S_SAT;
         S_UNSAT: state_d = S_UNSAT;

         default: state_d = S_BCP_WAIT;
      endcase
   end

   assign dec_idx_d_in   = dec_ptr_q;
   assign bcp_clause_idx = clause_idx_q;
   assign reset_bcp      = !reset || (state_q == S_BACKTRACK);
   assign sat            = (state_q == S_SAT);
   assign unsat          = (state_q == S_UNSAT);
   assign state_out      = state_q;

endmodule

// File: tb/tb_dpll_control.sv
// tb_dpll_control: directed scenario bench for the DPLL sequencer.
module tb_dpll_control;

   logic       clock;
   logic       reset;
   logic       start;
   logic       bcp_busy;
   logic       conflict;
   logic [9:0] bcp_clause_idx;
   logic       reset_bcp;
   logic       empty_imply;
   logic [7:0] var_out_imply;
   logic       val_out_imply;
   logic       type_out_imply;
   logic       pop_imply;
   logic       empty_trace;
   logic [7:0] var_out_trace;
   logic       val_out_trace;
   logic       type_out_trace;
   logic       pop_trace;
   logic       push_trace;
   logic [7:0] var_in_trace;
   logic       val_in_trace;
   logic       type_in_trace;
   logic       write_vs;
   logic [7:0] var_in_vs;
   logic       val_in_vs;
   logic       unassign_in_vs;
   logic [9:0] start_clause;
   logic [9:0] end_clause;
   logic       read_var_start_end;
   logic [7:0] var_in_vse;
   logic [7:0] var_idx_d;
   logic       val_d;
   logic       read_d;
   logic [7:0] dec_idx_d_in;
   logic [7:0] dec_idx_ds_out;
   logic       empty_ds;
   logic       push_ds;
   logic       pop_ds;
   logic [7:0] dec_idx_ds_in;
   logic       sat;
   logic       unsat;
   logic [3:0] state_out;

   int n_vec;
   int n_err;

   dpll_control #(.VAR_BITS(8), .CLAUSE_BITS(10)) dut (
      .clock(clock), .reset(reset), .start(start),
      .bcp_busy(bcp_busy), .conflict(conflict),
      .bcp_clause_idx(bcp_clause_idx), .reset_bcp(reset_bcp),
      .empty_imply(empty_imply), .var_out_imply(var_out_imply),
      .val_out_imply(val_out_imply), .type_out_imply(type_out_imply),
      .pop_imply(pop_imply),
      .empty_trace(empty_trace), .var_out_trace(var_out_trace),
      .val_out_trace(val_out_trace), .type_out_trace(type_out_trace),
      .pop_trace(pop_trace), .push_trace(push_trace),
      .var_in_trace(var_in_trace), .val_in_trace(val_in_trace),
      .type_in_trace(type_in_trace),
      .write_vs(write_vs), .var_in_vs(var_in_vs), .val_in_vs(val_in_vs),
      .unassign_in_vs(unassign_in_vs),
      .start_clause(start_clause), .end_clause(end_clause),
      .read_var_start_end(read_var_start_end), .var_in_vse(var_in_vse),
      .var_idx_d(var_idx_d), .val_d(val_d), .read_d(read_d),
      .dec_idx_d_in(dec_idx_d_in),
      .dec_idx_ds_out(dec_idx_ds_out), .empty_ds(empty_ds),
      .push_ds(push_ds), .pop_ds(pop_ds), .dec_idx_ds_in(dec_idx_ds_in),
      .sat(sat), .unsat(unsat), .state_out(state_out)
   );

   // clock generation
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // advance one clock; inputs may be changed right after this returns
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // let combinational outputs settle after an input change
   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      settle();
      n_vec++;
      if ({state_out, sat, unsat, reset_bcp} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_flags: got st=%0d sat=%b unsat=%b rb=%b, exp st=0 sat=0 unsat=0 rb=1",
                  state_out, sat, unsat, reset_bcp);
         n_err++;
      end
      n_vec++;
      if ({bcp_clause_idx, dec_idx_d_in} !== {10'd0, 8'd1}) begin
         $display("FAIL reset_regs: got clause=%0d dec_idx=%0d, exp 0 1", bcp_clause_idx, dec_idx_d_in);
         n_err++;
      end
      n_vec++;
      if ({pop_imply, pop_trace, push_trace, write_vs, read_d, read_var_start_end, push_ds, pop_ds} !== 8'h00) begin
         $display("FAIL reset_strobes: got %b exp 00000000",
                  {pop_imply, pop_trace, push_trace, write_vs, read_d, read_var_start_end, push_ds, pop_ds});
         n_err++;
      end
      tick();
      tick();
   endtask

   task automatic test_decide();
      bcp_busy = 1'b1;
      conflict = 1'b0;
      empty_imply = 1'b1;
      reset = 1'b1;
      tick();
      n_vec++;
      if ({state_out, reset_bcp} !== {4'd0, 1'b0}) begin
         $display("FAIL wait_busy: got st=%0d rb=%b exp st=0 rb=0", state_out, reset_bcp);
         n_err++;
      end
      bcp_busy = 1'b0;
      tick();
      settle();
      n_vec++;
      if ({state_out, pop_imply} !== {4'd1, 1'b0}) begin
         $display("FAIL imply_empty: got st=%0d pop=%b exp st=1 pop=0", state_out, pop_imply);
         n_err++;
      end
      tick();
      n_vec++;
      if ({state_out, read_d, dec_idx_d_in} !== {4'd2, 1'b1, 8'd1}) begin
         $display("FAIL decide_read: got st=%0d read_d=%b idx=%0d exp st=2 1 1", state_out, read_d, dec_idx_d_in);
         n_err++;
      end
      tick();
      var_idx_d = 8'd6;
      val_d = 1'b1;
      settle();
      n_vec++;
      if ({state_out, write_vs, var_in_vs, val_in_vs, unassign_in_vs} !== {4'd3, 1'b1, 8'd6, 1'b1, 1'b0}) begin
         $display("FAIL decide_write: got st=%0d wr=%b v=%0d val=%b un=%b exp st=3 1 6 1 0",
                  state_out, write_vs, var_in_vs, val_in_vs, unassign_in_vs);
         n_err++;
      end
      n_vec++;
      if ({push_trace, var_in_trace, val_in_trace, type_in_trace, push_ds, dec_idx_ds_in}
          !== {1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd1}) begin
         $display("FAIL decide_push: got pt=%b v=%0d val=%b ty=%b pds=%b ds=%0d exp 1 6 1 0 1 1",
                  push_trace, var_in_trace, val_in_trace, type_in_trace, push_ds, dec_idx_ds_in);
         n_err++;
      end
      tick();
      start_clause = 10'd37;
      settle();
      n_vec++;
      if ({state_out, read_var_start_end, var_in_vse} !== {4'd6, 1'b1, 8'd6}) begin
         $display("FAIL decide_vse: got st=%0d rd=%b v=%0d exp st=6 1 6", state_out, read_var_start_end, var_in_vse);
         n_err++;
      end
      bcp_busy = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({state_out, bcp_clause_idx, dec_idx_d_in} !== {4'd0, 10'd37, 8'd2}) begin
         $display("FAIL decide_launch: got st=%0d clause=%0d dptr=%0d exp st=0 37 2",
                  state_out, bcp_clause_idx, dec_idx_d_in);
         n_err++;
      end
   endtask

   task automatic test_backtrack_flip();
      // trace top is the decision var 5 = 1, with forced entries below it
      empty_trace = 1'b0;
      var_out_trace = 8'd5;
      val_out_trace = 1'b1;
      type_out_trace = 1'b0;
      empty_ds = 1'b0;
      dec_idx_ds_out = 8'd3;
      bcp_busy = 1'b0;
      conflict = 1'b1;
      tick();
      settle();
      n_vec++;
      if ({state_out, reset_bcp, pop_trace, write_vs} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
         $display("FAIL bt_pop_decision: got st=%0d rb=%b pop=%b wr=%b exp st=4 1 1 0",
                  state_out, reset_bcp, pop_trace, write_vs);
         n_err++;
      end
      tick();
      var_out_trace = 8'd9;
      val_out_trace = 1'b0;
      settle();
      n_vec++;
      if ({state_out, write_vs, var_in_vs, val_in_vs, unassign_in_vs, pop_ds, reset_bcp}
          !== {4'd5, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         $display("FAIL flip_write: got st=%0d wr=%b v=%0d val=%b un=%b pds=%b rb=%b exp st=5 1 5 0 0 1 0",
                  state_out, write_vs, var_in_vs, val_in_vs, unassign_in_vs, pop_ds, reset_bcp);
         n_err++;
      end
      n_vec++;
      if ({push_trace, var_in_trace, val_in_trace, type_in_trace} !== {1'b1, 8'd5, 1'b0, 1'b1}) begin
         $display("FAIL flip_push: got pt=%b v=%0d val=%b ty=%b exp 1 5 0 1",
                  push_trace, var_in_trace, val_in_trace, type_in_trace);
         n_err++;
      end
      tick();
      start_clause = 10'd0;
      end_clause = 10'd10;
      settle();
      n_vec++;
      if ({state_out, read_var_start_end, var_in_vse, dec_idx_d_in} !== {4'd6, 1'b1, 8'd5, 8'd4}) begin
         $display("FAIL flip_vse: got st=%0d rd=%b v=%0d dptr=%0d exp st=6 1 5 4",
                  state_out, read_var_start_end, var_in_vse, dec_idx_d_in);
         n_err++;
      end
      bcp_busy = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({state_out, bcp_clause_idx} !== {4'd0, 10'd0}) begin
         $display("FAIL flip_launch: got st=%0d clause=%0d exp st=0 0", state_out, bcp_clause_idx);
         n_err++;
      end
      // conflict stays high but must be ignored while busy
      for (int i = 0; i < 13; i++) begin
         tick();
         n_vec++;
         if (state_out !== 4'd0) begin
            $display("FAIL busy_hold_%0d: got st=%0d exp 0", i, state_out);
            n_err++;
         end
      end
   endtask

   task automatic test_unassign();
      empty_trace = 1'b0;
      var_out_trace = 8'd7;
      val_out_trace = 1'b1;
      type_out_trace = 1'b1;
      empty_ds = 1'b1;
      dec_idx_ds_out = 8'd20;
      bcp_busy = 1'b0;
      conflict = 1'b1;
      tick();
      settle();
      n_vec++;
      if ({state_out, pop_trace, write_vs, var_in_vs, unassign_in_vs} !== {4'd4, 1'b1, 1'b1, 8'd7, 1'b1}) begin
         $display("FAIL unassign_7: got st=%0d pop=%b wr=%b v=%0d un=%b exp st=4 1 1 7 1",
                  state_out, pop_trace, write_vs, var_in_vs, unassign_in_vs);
         n_err++;
      end
      tick();
      var_out_trace = 8'd3;
      val_out_trace = 1'b0;
      settle();
      n_vec++;
      if ({state_out, pop_trace, write_vs, var_in_vs, unassign_in_vs} !== {4'd4, 1'b1, 1'b1, 8'd3, 1'b1}) begin
         $display("FAIL unassign_3: got st=%0d pop=%b wr=%b v=%0d un=%b exp st=4 1 1 3 1",
                  state_out, pop_trace, write_vs, var_in_vs, unassign_in_vs);
         n_err++;
      end
      tick();
      var_out_trace = 8'd2;
      val_out_trace = 1'b0;
      type_out_trace = 1'b0;
      tick();
      empty_trace = 1'b1;
      settle();
      n_vec++;
      if ({state_out, write_vs, var_in_vs, val_in_vs, push_trace, pop_ds} !== {4'd5, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0}) begin
         $display("FAIL flip_empty_ds: got st=%0d wr=%b v=%0d val=%b pt=%b pds=%b exp st=5 1 2 1 1 0",
                  state_out, write_vs, var_in_vs, val_in_vs, push_trace, pop_ds);
         n_err++;
      end
      tick();
      n_vec++;
      if ({state_out, dec_idx_d_in, var_in_vse} !== {4'd6, 8'd4, 8'd2}) begin
         $display("FAIL flip_empty_ds_ptr: got st=%0d dptr=%0d v=%0d exp st=6 4 2", state_out, dec_idx_d_in, var_in_vse);
         n_err++;
      end
   endtask

   task automatic test_unsat();
      // asynchronous abort from the middle of the flow
      reset = 1'b0;
      settle();
      n_vec++;
      if ({state_out, reset_bcp, dec_idx_d_in} !== {4'd0, 1'b1, 8'd1}) begin
         $display("FAIL async_abort: got st=%0d rb=%b dptr=%0d exp st=0 1 1", state_out, reset_bcp, dec_idx_d_in);
         n_err++;
      end
      tick();
      empty_trace = 1'b1;
      bcp_busy = 1'b0;
      conflict = 1'b1;
      reset = 1'b1;
      tick();
      settle();
      n_vec++;
      if ({state_out, reset_bcp, pop_trace, unsat} !== {4'd4, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL unsat_bt: got st=%0d rb=%b pop=%b unsat=%b exp st=4 1 0 0",
                  state_out, reset_bcp, pop_trace, unsat);
         n_err++;
      end
      tick();
      tick();
      tick();
      n_vec++;
      if ({state_out, unsat, sat, reset_bcp, pop_trace, write_vs} !== {4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL unsat_sticky: got st=%0d unsat=%b sat=%b rb=%b pop=%b wr=%b exp st=9 1 0 0 0 0",
                  state_out, unsat, sat, reset_bcp, pop_trace, write_vs);
         n_err++;
      end
   endtask

   task automatic test_imply_sat();
      reset = 1'b0;
      tick();
      empty_imply = 1'b0;
      var_out_imply = 8'd4;
      val_out_imply = 1'b1;
      type_out_imply = 1'b1;
      bcp_busy = 1'b0;
      conflict = 1'b0;
      reset = 1'b1;
      tick();
      settle();
      n_vec++;
      if ({state_out, pop_imply, write_vs, var_in_vs, val_in_vs} !== {4'd1, 1'b1, 1'b1, 8'd4, 1'b1}) begin
         $display("FAIL imply_pop: got st=%0d pop=%b wr=%b v=%0d val=%b exp st=1 1 1 4 1",
                  state_out, pop_imply, write_vs, var_in_vs, val_in_vs);
         n_err++;
      end
      n_vec++;
      if ({push_trace, var_in_trace, val_in_trace, type_in_trace} !== {1'b1, 8'd4, 1'b1, 1'b1}) begin
         $display("FAIL imply_push: got pt=%b v=%0d val=%b ty=%b exp 1 4 1 1",
                  push_trace, var_in_trace, val_in_trace, type_in_trace);
         n_err++;
      end
      tick();
      empty_imply = 1'b1;
      settle();
      n_vec++;
      if ({state_out, var_in_vse} !== {4'd6, 8'd4}) begin
         $display("FAIL imply_vse: got st=%0d v=%0d exp st=6 4", state_out, var_in_vse);
         n_err++;
      end
      tick();
      tick();
      tick();
      tick();
      n_vec++;
      if (state_out !== 4'd2) begin
         $display("FAIL sat_decide: got st=%0d exp 2", state_out);
         n_err++;
      end
      tick();
      var_idx_d = 8'd0;
      settle();
      n_vec++;
      if ({state_out, write_vs, push_ds, push_trace} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL sat_sentinel: got st=%0d wr=%b pds=%b pt=%b exp st=3 0 0 0",
                  state_out, write_vs, push_ds, push_trace);
         n_err++;
      end
      tick();
      tick();
      tick();
      n_vec++;
      if ({state_out, sat, unsat} !== {4'd8, 1'b1, 1'b0}) begin
         $display("FAIL sat_sticky: got st=%0d sat=%b unsat=%b exp st=8 1 0", state_out, sat, unsat);
         n_err++;
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      start = 1'b0;
      bcp_busy = 1'b1;
      conflict = 1'b0;
      empty_imply = 1'b1;
      var_out_imply = '0;
      val_out_imply = 1'b0;
      type_out_imply = 1'b0;
      empty_trace = 1'b1;
      var_out_trace = '0;
      val_out_trace = 1'b0;
      type_out_trace = 1'b0;
      start_clause = '0;
      end_clause = '0;
      var_idx_d = '0;
      val_d = 1'b0;
      dec_idx_ds_out = '0;
      empty_ds = 1'b1;
      tick();
      test_reset();
      test_decide();
      test_backtrack_flip();
      test_unassign();
      test_unsat();
      test_imply_sat();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
